hood_status_tracker: RTL
========================

// Module: hood_status_tracker
// PURPOSE
//  Registered successor of the combinational state decoder, parametrised on fan level count.
//  Takes the main FSM state code and a 1 s tick and produces registered status flags and the active fan level.
//  Runs the timed-mode countdown (top level, self-clean, wait-to-standby) and returns a done pulse to the FSM.
//  Accumulates working time and raises a clean-reminder.
// PARAMETERS
//  NUM_LEVELS        3      fan levels; level k (1..N) coded 2+k; SELF_CLEAN=N+3; WAIT_TO_STANDBY=N+4
//  STATE_W           3      state code width, >= clog2(NUM_LEVELS+5)
//  TOP_LVL_SEC       60     run time of level NUM_LEVELS before done
//  SELF_CLEAN_SEC    180    self-clean duration
//  WAIT_SEC          60     wait-to-standby duration
//  CNT_W             8      countdown width; must hold max of the three durations
//  WORK_W            20     working-time accumulator width
//  CLEAN_THRESH_SEC  36000  work_sec value at which clean_reminder sets
// PORTS
//  clk                 in   1        system clock
//  rst_n               in   1        asynchronous active-low reset
//  state               in   STATE_W  current main-FSM state; OFF=0 STANDBY=1 MODE_SELECT=2
//  tick_1s             in   1        one-cycle pulse per second
//  is_power_on         out  1        state != OFF and state is legal
//  is_working          out  1        state is any fan level
//  is_self_clean       out  1        state == SELF_CLEAN
//  is_standby          out  1        state == STANDBY
//  is_countdown_active out  1        state is top level, SELF_CLEAN or WAIT_TO_STANDBY
//  fan_level           out  clog2(NUM_LEVELS+1)  1..N while working, else 0
//  remain_sec          out  CNT_W    seconds left in active countdown, else 0
//  countdown_done      out  1        one-cycle pulse when remain_sec reaches 0
//  work_sec            out  WORK_W   accumulated working seconds
//  clean_reminder      out  1        work_sec >= CLEAN_THRESH_SEC
// BEHAVIOUR
//  - Reset: all outputs 0. prev_state = OFF.
//  - Flags and fan_level are registered, 1 cycle after state. Illegal codes (> N+4) decode as OFF:
//    all flags 0, countdown cleared.
//  - Entry detection: state != prev_state and state is a countdown state.
//    On entry, remain_sec loads the matching duration on that edge. A tick_1s in the same cycle is ignored.
//  - Otherwise, while in a countdown state: on tick_1s with remain_sec > 0, decrement.
//    The 1 -> 0 transition pulses countdown_done for exactly one cycle.
//  - At 0: hold at 0, no further pulses until the state is re-entered.
//  - Leaving a countdown state (incl. to another countdown state) before 0:
//    - the new state's duration loads, or 0 if the new state is not a countdown state;
//    - no done pulse.
//  - Top level -> lower level -> top level reloads TOP_LVL_SEC.
//  - work_sec: +1 on tick_1s while state (input, unregistered) is a fan level.
//    Saturates at 2^WORK_W-1. Persists across OFF; only rst_n clears it asynchronously.
//  - Self-clean completion: countdown_done while in SELF_CLEAN sets work_sec = 0 on the same edge.
//    Clear wins over a coincident increment. clean_reminder deasserts next cycle.
//  - clean_reminder is registered from the comparison, with 1-cycle lag after work_sec.
//  - rst_n low mid-countdown: immediate clear. After release, the current state counts as a fresh entry
//    (prev_state = OFF).
// STRUCTURE
//  - Package hood_pkg holds state code constants:
//    ST_OFF, ST_STANDBY, ST_MODE_SELECT, ST_LEVEL_BASE,
//    functions st_level(k), st_self_clean(n), st_wait(n), is_level(code, n).
//  - One sub-module, hood_countdown (CNT_W): inputs load, load_val, dec, clr; outputs cnt, done.
//  - Decode, entry detect and accumulator live in the top.
// TESTING
//  1. rst_n=0 with state=3'b011 and ticks running -> all outputs 0; release -> next cycle is_working=1,
//     fan_level=1, remain_sec=0.
//  2. state=5 (L3), 60 ticks -> remain_sec 60..0. countdown_done is a single pulse on the 60th tick;
//     no further pulse after 5 more ticks.
//  3. L3 for 10 ticks, then state=3 (L1), then L3 -> remain_sec 50 -> 0 -> 60, no done pulse;
//     tick coincident with re-entry -> 60, not 59.
//  4. CLEAN_THRESH_SEC=5: 5 ticks in L2 -> work_sec=5, clean_reminder=1. state=OFF -> values held.
//     SELF_CLEAN 180 ticks -> done pulse, work_sec=0, clean_reminder=0.
//  5. WORK_W=3: 9 ticks in L1 -> work_sec saturates at 7. state=3'b111 with NUM_LEVELS=2 (illegal code)
//     -> all flags 0.
//  6. WAIT_TO_STANDBY at remain_sec=20, assert rst_n=0 for 1 cycle -> remain_sec=0 asynchronously.
//     After release -> reload to 60.

Source files
------------

// File: rtl/hood_status_tracker_pkg.sv
// State-code constants and helpers shared by the hood status tracker.
// Fan level k (1..n) is coded ST_LEVEL_BASE+k; self-clean and wait-to-standby
// follow directly after the highest level.
package hood_pkg;

  localparam int ST_OFF         = 0;
  localparam int ST_STANDBY     = 1;
  localparam int ST_MODE_SELECT = 2;
  localparam int ST_LEVEL_BASE  = 2;

  function automatic int st_level(int k);
    return ST_LEVEL_BASE + k;
  endfunction

  function automatic int st_self_clean(int n);
    return n + 3;
  endfunction

  function automatic int st_wait(int n);
    return n + 4;
  endfunction

  function automatic logic is_level(int code, int n);
    return (code >= st_level(1)) && (code <= st_level(n));
  endfunction

endpackage

// File: rtl/hood_status_tracker_if.sv
// Status bus between the main hood FSM and the status tracker.
// Signalling: there is no valid/ready handshake. state is a level that the
// tracker samples every clock; tick_1s is a single-cycle strobe once per
// second; every status output is a registered level except countdown_done,
// which is a single-cycle strobe back to the FSM.
interface hood_status_tracker_if #(
  parameter int NUM_LEVELS = 3,
  parameter int STATE_W    = 3,
  parameter int CNT_W      = 8,
  parameter int WORK_W     = 20
);
  localparam int FAN_W = $clog2(NUM_LEVELS + 1);

  logic [STATE_W-1:0] state;
  logic               tick_1s;
  logic               is_power_on;
  logic               is_working;
  logic               is_self_clean;
  logic               is_standby;
  logic               is_countdown_active;
  logic [FAN_W-1:0]   fan_level;
  logic [CNT_W-1:0]   remain_sec;
  logic               countdown_done;
  logic [WORK_W-1:0]  work_sec;
  logic               clean_reminder;

  modport master (
    output state, tick_1s,
    input  is_power_on, is_working, is_self_clean, is_standby,
           is_countdown_active, fan_level, remain_sec, countdown_done,
           work_sec, clean_reminder
  );

  modport slave (
    input  state, tick_1s,
    output is_power_on, is_working, is_self_clean, is_standby,
           is_countdown_active, fan_level, remain_sec, countdown_done,
           work_sec, clean_reminder
  );
endinterface

// File: rtl/hood_status_tracker_countdown.sv
// Seconds countdown: clear beats load beats decrement. done strobes for one
// cycle on the edge where the count steps from 1 to 0, and never again while
// the count sits at 0.
module hood_countdown #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  // Counter register and its single-cycle completion strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (load) begin
        cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
        cnt  <= cnt - CNT_W'(1);
        done <= (cnt == CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/hood_status_tracker.sv
// Registered status decoder for the hood main FSM: status flags, fan level,
// timed-mode countdown with done strobe, working-time accumulator and
// clean reminder.
import hood_pkg::*;

module hood_status_tracker #(
  parameter int NUM_LEVELS       = 3,
  parameter int STATE_W          = 3,
  parameter int TOP_LVL_SEC      = 60,
  parameter int SELF_CLEAN_SEC   = 180,
  parameter int WAIT_SEC         = 60,
  parameter int CNT_W            = 8,
  parameter int WORK_W           = 20,
  parameter int CLEAN_THRESH_SEC = 36000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hood_status_tracker_if.slave  bus
);

  localparam int FAN_W = $clog2(NUM_LEVELS + 1);

  localparam logic [STATE_W-1:0] S_OFF     = STATE_W'(ST_OFF);
  localparam logic [STATE_W-1:0] S_STANDBY = STATE_W'(ST_STANDBY);
  localparam logic [STATE_W-1:0] S_TOP     = STATE_W'(st_level(NUM_LEVELS));
  localparam logic [STATE_W-1:0] S_SC      = STATE_W'(st_self_clean(NUM_LEVELS));
  localparam logic [STATE_W-1:0] S_WAIT    = STATE_W'(st_wait(NUM_LEVELS));
  localparam logic [31:0]        THRESH    = 32'(CLEAN_THRESH_SEC);

  logic               legal;
  logic               lvl;
  logic               cd_state;
  logic               entry;
  logic               dec;
  logic               clr;
  logic               sc_finish;
  logic [CNT_W-1:0]   load_val;
  logic [CNT_W-1:0]   cnt;
  logic               done;
  logic [STATE_W-1:0] prev_state;
  logic [WORK_W-1:0]  work_q;

  // Decode the live state code: legality, fan level, countdown entry and tick use.
  always_comb begin
    legal     = int'(bus.state) <= st_wait(NUM_LEVELS);
    lvl       = is_level(int'(bus.state), NUM_LEVELS);
    cd_state  = (bus.state == S_TOP) || (bus.state == S_SC) || (bus.state == S_WAIT);
    // A tick in the entry cycle is swallowed so the full duration is shown first.
    entry     = cd_state && (bus.state != prev_state);
    dec       = cd_state && !entry && bus.tick_1s;
    // Outside a countdown state (including illegal codes) the count is forced to 0.
    clr       = !cd_state;
    load_val  = '0;
    if (bus.state == S_TOP)  load_val = CNT_W'(TOP_LVL_SEC);
    if (bus.state == S_SC)   load_val = CNT_W'(SELF_CLEAN_SEC);
    if (bus.state == S_WAIT) load_val = CNT_W'(WAIT_SEC);
    // Same edge on which the counter raises done while self-cleaning.
    sc_finish = (bus.state == S_SC) && dec && (cnt == CNT_W'(1));
  end

  hood_countdown #(.CNT_W(CNT_W)) u_countdown (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (entry),
    .load_val (load_val),
    .dec      (dec),
    .clr      (clr),
    .cnt      (cnt),
    .done     (done)
  );

  // Register the status flags, fan level and the previous state for entry detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.is_power_on         <= 1'b0;
      bus.is_working          <= 1'b0;
      bus.is_self_clean       <= 1'b0;
      bus.is_standby          <= 1'b0;
      bus.is_countdown_active <= 1'b0;
      bus.fan_level           <= '0;
      prev_state              <= S_OFF;
    end else begin
      bus.is_power_on         <= legal && (bus.state != S_OFF);
      bus.is_working          <= lvl;
      bus.is_self_clean       <= (bus.state == S_SC);
      bus.is_standby          <= (bus.state == S_STANDBY);
      bus.is_countdown_active <= cd_state;
      bus.fan_level           <= lvl ? FAN_W'(int'(bus.state) - ST_LEVEL_BASE) : '0;
      prev_state              <= bus.state;
    end
  end

  // Saturating working-time accumulator; self-clean completion clears it and wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q             <= '0;
      bus.clean_reminder <= 1'b0;
    end else begin
      if (sc_finish) begin
        work_q <= '0;
      end else if (lvl && bus.tick_1s && (work_q != '1)) begin
        work_q <= work_q + WORK_W'(1);
      end
      bus.clean_reminder <= (32'(work_q) >= THRESH);
    end
  end

  assign bus.remain_sec     = cnt;
  assign bus.countdown_done = done;
  assign bus.work_sec       = work_q;

endmodule
